// File: rtl/mtip_ipg_gen.sv
// RX smoother between the MTIP RX FIFO interface and the Frame Extractor: show-ahead FIFO,
// input framing sanitiser and programmable output interpacket gap. MTIP_IPG_STATS_EN adds counters.
module mtip_ipg_gen #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FIFO_AW = 8,
  parameter int unsigned IPG_W   = 4
) (
  input  logic                 iCLK,
  input  logic                 iRESET_n,
  input  logic [IPG_W-1:0]     iIPG_CNT,
  input  logic [DATA_W-1:0]    iMTIP_DATA,
  input  logic                 iMTIP_DVAL,
  input  logic                 iMTIP_SOP,
  input  logic                 iMTIP_EOP,
  input  logic                 iMTIP_ERR,
  output logic [DATA_W-1:0]    oDATA,
  output logic                 oSOP,
  output logic                 oEOP,
  output logic                 oERR,
  output logic                 oDVAL,
  output logic [DATA_W-1:0]    oDATA_P0,
  output logic                 oSOP_P0,
  output logic                 oEOP_P0,
  output logic                 oERR_P0,
  output logic                 oDVAL_P0,
  output logic                 oFIFO_FULL,
  output logic [FIFO_AW:0]     oFIFO_LEVEL,
  output logic                 oTRUNC
`ifdef MTIP_IPG_STATS_EN
  ,
  output logic [31:0]          oFRAME_CNT,
  output logic [15:0]          oTRUNC_CNT
`endif
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned EW    = DATA_W + 3;
  localparam int unsigned LVL_W = FIFO_AW + 1;

  localparam logic [LVL_W-1:0] LvlDepth   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LvlDropSop = LVL_W'(DEPTH - 2);
  localparam logic [LVL_W-1:0] LvlCutWord = LVL_W'(DEPTH - 1);

  localparam logic [1:0] InWaitSop = 2'd0;
  localparam logic [1:0] InFrame   = 2'd1;
  localparam logic [1:0] InDiscard = 2'd2;

  localparam int unsigned IdxIdle = 0;
  localparam int unsigned IdxRead = 1;
  localparam int unsigned IdxIpg  = 2;
  localparam logic [2:0] OsIdle = 3'b001;
  localparam logic [2:0] OsRead = 3'b010;
  localparam logic [2:0] OsIpg  = 3'b100;

  // FIFO storage and pointers
  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wrPtrQ, rdPtrQ;
  logic [LVL_W-1:0]   levelQ, levelD;
  logic               fifoEmpty;

  logic [EW-1:0]      headWord;
  logic [DATA_W-1:0]  headData;
  logic               headSop, headEop, headErr;

  logic [1:0]         inStateQ, inStateD;
  logic               wrEn, wrSop, wrEop, wrErr, truncD;

  logic [2:0]         outStateQ, outStateD;
  logic [IPG_W-1:0]   ipgCntQ, ipgCntD, ipgMin;
  logic               rdEn, emit;

  assign fifoEmpty = (levelQ == '0);
  assign headWord  = mem[rdPtrQ];
  assign headData  = headWord[DATA_W-1:0];
  assign headSop   = headWord[DATA_W];
  assign headEop   = headWord[DATA_W+1];
  assign headErr   = headWord[DATA_W+2];

  assign ipgMin = (iIPG_CNT < IPG_W'(2)) ? IPG_W'(2) : iIPG_CNT;

  // Input sanitiser: only well-framed words reach the FIFO, so it can never overflow.
  always_comb begin
    inStateD = inStateQ;
    wrEn     = 1'b0;
    wrSop    = iMTIP_SOP;
    wrEop    = iMTIP_EOP;
    wrErr    = iMTIP_ERR;
    truncD   = 1'b0;
    if (iMTIP_DVAL) begin
      case (inStateQ)
        InFrame: begin
          wrEn = 1'b1;
          if (iMTIP_SOP) begin
            // Missing EOP: close the open frame on this word, lose the new one.
            wrSop    = 1'b0;
            wrEop    = 1'b1;
            wrErr    = 1'b1;
            truncD   = 1'b1;
            inStateD = InDiscard;
          end else if (iMTIP_EOP) begin
            inStateD = InWaitSop;
          end else if (levelQ >= LvlCutWord) begin
            wrEop    = 1'b1;
            wrErr    = 1'b1;
            truncD   = 1'b1;
            inStateD = InDiscard;
          end
        end
        default: begin
          // WAIT_SOP and DISCARD treat a SOP identically.
          if (iMTIP_SOP) begin
            if (levelQ >= LvlDropSop) begin
              truncD   = 1'b1;
              inStateD = iMTIP_EOP ? InWaitSop : InDiscard;
            end else begin
              wrEn     = 1'b1;
              inStateD = iMTIP_EOP ? InWaitSop : InFrame;
            end
          end else if (iMTIP_EOP) begin
            inStateD = InWaitSop;
          end
        end
      endcase
    end
  end

  // Output pacing FSM
  always_comb begin
    outStateD = outStateQ;
    ipgCntD   = ipgCntQ;
    rdEn      = 1'b0;
    emit      = 1'b0;
    unique case (1'b1)
      outStateQ[IdxIdle]: begin
        if (!fifoEmpty) begin
          rdEn = 1'b1;
          if (headSop) begin
            emit      = 1'b1;
            ipgCntD   = ipgMin;
            // A single-word frame goes straight to the gap.
            outStateD = headEop ? OsIpg : OsRead;
          end
        end
      end
      outStateQ[IdxRead]: begin
        if (!fifoEmpty) begin
          rdEn = 1'b1;
          emit = 1'b1;
          if (headEop) outStateD = OsIpg;
        end
      end
      outStateQ[IdxIpg]: begin
        if (ipgCntQ <= IPG_W'(1)) begin
          ipgCntD   = '0;
          outStateD = OsIdle;
        end else begin
          ipgCntD = ipgCntQ - IPG_W'(1);
        end
      end
      default: outStateD = OsIdle;
    endcase
  end

  assign levelD = levelQ + LVL_W'(wrEn) - LVL_W'(rdEn);

  always_ff @(posedge iCLK) begin
    if (wrEn) mem[wrPtrQ] <= {wrErr, wrEop, wrSop, iMTIP_DATA};
  end

  always_ff @(posedge iCLK or negedge iRESET_n) begin
    if (!iRESET_n) begin
      wrPtrQ      <= '0;
      rdPtrQ      <= '0;
      levelQ      <= '0;
      oFIFO_FULL  <= 1'b0;
      inStateQ    <= InWaitSop;
      outStateQ   <= OsIdle;
      ipgCntQ     <= '0;
      oTRUNC      <= 1'b0;
    end else begin
      if (wrEn) wrPtrQ <= wrPtrQ + FIFO_AW'(1);
      if (rdEn) rdPtrQ <= rdPtrQ + FIFO_AW'(1);
      levelQ      <= levelD;
      oFIFO_FULL  <= (levelD == LvlDepth);
      inStateQ    <= inStateD;
      outStateQ   <= outStateD;
      ipgCntQ     <= ipgCntD;
      oTRUNC      <= truncD;
    end
  end

  assign oFIFO_LEVEL = levelQ;

  // Early outputs, then the one-stage delayed _P0 copies.
  always_ff @(posedge iCLK or negedge iRESET_n) begin
    if (!iRESET_n) begin
      oDVAL    <= 1'b0;
      oSOP     <= 1'b0;
      oEOP     <= 1'b0;
      oERR     <= 1'b0;
      oDATA    <= '0;
      oDVAL_P0 <= 1'b0;
      oSOP_P0  <= 1'b0;
      oEOP_P0  <= 1'b0;
      oERR_P0  <= 1'b0;
      oDATA_P0 <= '0;
    end else begin
      oDVAL    <= emit;
      oSOP     <= emit & headSop;
      oEOP     <= emit & headEop;
      oERR     <= emit & headErr;
      oDATA    <= emit ? headData : '0;
      oDVAL_P0 <= oDVAL;
      oSOP_P0  <= oSOP;
      oEOP_P0  <= oEOP;
      oERR_P0  <= oERR;
      oDATA_P0 <= oDATA;
    end
  end

`ifdef MTIP_IPG_STATS_EN
  logic [31:0] frameCntQ;
  logic [15:0] truncCntQ;

  always_ff @(posedge iCLK or negedge iRESET_n) begin
    if (!iRESET_n) begin
      frameCntQ <= '0;
      truncCntQ <= '0;
    end else begin
      if (oEOP_P0) frameCntQ <= frameCntQ + 32'd1;
      if (oTRUNC)  truncCntQ <= truncCntQ + 16'd1;
    end
  end

  assign oFRAME_CNT = frameCntQ;
  assign oTRUNC_CNT = truncCntQ;
`endif

endmodule

// File: tb/tb_mtip_ipg_gen.sv
// Self-checking bench for mtip_ipg_gen: gap table, directed framing sequences and random
// traffic checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_mtip_ipg_gen;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned IPG_W   = 4;
  localparam int          DEPTH   = 16;
  localparam int          VW      = 2 * (DATA_W + 4) + 2 + FIFO_AW + 1;

  logic               iCLK = 1'b0;
  logic               iRESET_n = 1'b0;
  logic [IPG_W-1:0]   iIPG_CNT = '0;
  logic [DATA_W-1:0]  iMTIP_DATA = '0;
  logic               iMTIP_DVAL = 1'b0, iMTIP_SOP = 1'b0, iMTIP_EOP = 1'b0, iMTIP_ERR = 1'b0;
  logic [DATA_W-1:0]  oDATA, oDATA_P0;
  logic               oSOP, oEOP, oERR, oDVAL, oSOP_P0, oEOP_P0, oERR_P0, oDVAL_P0;
  logic               oFIFO_FULL, oTRUNC;
  logic [FIFO_AW:0]   oFIFO_LEVEL;
`ifdef MTIP_IPG_STATS_EN
  logic [31:0]        oFRAME_CNT;
  logic [15:0]        oTRUNC_CNT;
`endif

  mtip_ipg_gen #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .IPG_W(IPG_W)) dut (
    .iCLK(iCLK), .iRESET_n(iRESET_n), .iIPG_CNT(iIPG_CNT),
    .iMTIP_DATA(iMTIP_DATA), .iMTIP_DVAL(iMTIP_DVAL), .iMTIP_SOP(iMTIP_SOP),
    .iMTIP_EOP(iMTIP_EOP), .iMTIP_ERR(iMTIP_ERR),
    .oDATA(oDATA), .oSOP(oSOP), .oEOP(oEOP), .oERR(oERR), .oDVAL(oDVAL),
    .oDATA_P0(oDATA_P0), .oSOP_P0(oSOP_P0), .oEOP_P0(oEOP_P0), .oERR_P0(oERR_P0),
    .oDVAL_P0(oDVAL_P0), .oFIFO_FULL(oFIFO_FULL), .oFIFO_LEVEL(oFIFO_LEVEL), .oTRUNC(oTRUNC)
`ifdef MTIP_IPG_STATS_EN
    , .oFRAME_CNT(oFRAME_CNT), .oTRUNC_CNT(oTRUNC_CNT)
`endif
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic sop; logic eop; logic err; logic [DATA_W-1:0] data;
  } word_t;
  typedef struct packed {
    logic dval; logic sop; logic eop; logic err; logic [DATA_W-1:0] data; logic trunc;
  } obs_t;
  typedef struct { int ipg; int gap; int words; } gap_vec_t;

  int nChecks = 0, nPass = 0, cyc = 0;

  // Reference model: FIFO as a queue, one "frame open" bit per side, a quiet-cycle budget.
  word_t mq[$];
  bit    mAccept, mOutOpen;
  int    mQuiet, mGap;
  logic [DATA_W+3:0] eEarly, eP0;
  logic              eTrunc, eFull;
  logic [FIFO_AW:0]  eLevel;

  obs_t log[$];
  obs_t vw[$];
  logic [DATA_W-1:0] sent[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s (t=%0t cycle %0d): actual %0h required %0h", name, $time, cyc, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    mAccept = 0; mOutOpen = 0; mQuiet = 0; mGap = 2;
    eEarly = '0; eP0 = '0; eTrunc = 0; eFull = 0; eLevel = '0;
  endtask

  task automatic model_step();
    int lvl;
    word_t w, h;
    logic tr, wr;
    logic [DATA_W+3:0] nEarly;
    lvl = mq.size(); tr = 0; wr = 0; nEarly = '0;
    w.sop = iMTIP_SOP; w.eop = iMTIP_EOP; w.err = iMTIP_ERR; w.data = iMTIP_DATA;
    if (iMTIP_DVAL) begin
      if (mAccept) begin
        wr = 1;
        if (iMTIP_SOP) begin
          w.sop = 0; w.eop = 1; w.err = 1; tr = 1; mAccept = 0;
        end else if (iMTIP_EOP) begin
          mAccept = 0;
        end else if (lvl >= DEPTH - 1) begin
          w.eop = 1; w.err = 1; tr = 1; mAccept = 0;
        end
      end else if (iMTIP_SOP) begin
        if (lvl >= DEPTH - 2) tr = 1;
        else begin
          wr = 1; mAccept = !iMTIP_EOP;
        end
      end
    end
    if (mOutOpen) begin
      if (lvl > 0) begin
        h = mq.pop_front();
        nEarly = {1'b1, h.sop, h.eop, h.err, h.data};
        if (h.eop) begin
          mOutOpen = 0; mQuiet = mGap;
        end
      end
    end else if (mQuiet > 0) begin
      mQuiet--;
    end else if (lvl > 0) begin
      h = mq.pop_front();
      if (h.sop) begin
        nEarly = {1'b1, h.sop, h.eop, h.err, h.data};
        mGap = (int'(iIPG_CNT) < 2) ? 2 : int'(iIPG_CNT);
        if (h.eop) mQuiet = mGap;
        else mOutOpen = 1;
      end
    end
    if (wr) mq.push_back(w);
    eP0 = eEarly; eEarly = nEarly; eTrunc = tr;
    eLevel = (FIFO_AW + 1)'(mq.size()); eFull = (mq.size() == DEPTH);
  endtask

  task automatic check_cycle(input string name);
    logic [VW-1:0] act, exp;
    act = {oDVAL, oSOP, oEOP, oERR, oDATA, oDVAL_P0, oSOP_P0, oEOP_P0, oERR_P0, oDATA_P0,
           oTRUNC, oFIFO_FULL, oFIFO_LEVEL};
    exp = {eEarly, eP0, eTrunc, eFull, eLevel};
    chk(name, 128'(act), 128'(exp));
  endtask

  task automatic step();
    model_step();
    @(posedge iCLK); #1;
    cyc++;
    check_cycle("cycle");
    log.push_back('{oDVAL_P0, oSOP_P0, oEOP_P0, oERR_P0, oDATA_P0, oTRUNC});
  endtask

  task automatic send(input logic sop, input logic eop, input logic err, input logic [31:0] d);
    iMTIP_DVAL = 1; iMTIP_SOP = sop; iMTIP_EOP = eop; iMTIP_ERR = err; iMTIP_DATA = d;
    step();
  endtask

  task automatic idle(input int n);
    iMTIP_DVAL = 0; iMTIP_SOP = 0; iMTIP_EOP = 0; iMTIP_ERR = 0; iMTIP_DATA = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      send(i == 0, i == n - 1, 1'b0, base + 32'(i));
      sent.push_back(base + 32'(i));
    end
  endtask

  task automatic apply_reset(input string name);
    iMTIP_DVAL = 0; iMTIP_SOP = 0; iMTIP_EOP = 0; iMTIP_ERR = 0;
    iRESET_n = 0;
    #2;
    model_reset();
    check_cycle(name);
    chk({name, " level"}, 128'(oFIFO_LEVEL), 128'(0));
    @(posedge iCLK); #1;
    iRESET_n = 1;
  endtask

  task automatic collect();
    vw.delete();
    foreach (log[i]) if (log[i].dval) vw.push_back(log[i]);
  endtask

  function automatic int trunc_count();
    int n = 0;
    foreach (log[i]) if (log[i].trunc) n++;
    return n;
  endfunction

  function automatic int data_errs();
    int n = (vw.size() != sent.size()) ? 1 : 0;
    for (int i = 0; i < vw.size() && i < sent.size(); i++) if (vw[i].data !== sent[i]) n++;
    return n;
  endfunction

  function automatic logic [2:0] flags_at(input int i);
    if (i < vw.size()) return {vw[i].sop, vw[i].eop, vw[i].err};
    return 3'b111;
  endfunction

  function automatic int gap_cycles();
    int e1 = -1;
    foreach (log[i]) begin
      if (e1 < 0 && log[i].dval && log[i].eop) e1 = i;
      else if (e1 >= 0 && log[i].dval && log[i].sop) return i - e1 - 1;
    end
    return -1;
  endfunction

  gap_vec_t gapTab [5];

  initial begin
    gapTab[0] = '{2, 2, 8};
    gapTab[1] = '{0, 2, 8};
    gapTab[2] = '{1, 2, 8};
    gapTab[3] = '{7, 7, 8};
    gapTab[4] = '{15, 15, 8};

    apply_reset("reset");

    // Back-to-back 4-word frames: gap on the _P0 stream follows max(iIPG_CNT, 2).
    for (int r = 0; r < 5; r++) begin
      iIPG_CNT = IPG_W'(gapTab[r].ipg);
      log.delete(); sent.delete();
      send_frame(4, 32'h1000 * (r + 1) + 32'hA0);
      send_frame(4, 32'h1000 * (r + 1) + 32'hB0);
      idle(45);
      collect();
      chk($sformatf("gap ipg=%0d", gapTab[r].ipg), 128'(gap_cycles()), 128'(gapTab[r].gap));
      chk("gap words", 128'(vw.size()), 128'(gapTab[r].words));
      chk("gap data order", 128'(data_errs()), 128'(0));
      chk("gap trunc", 128'(trunc_count()), 128'(0));
    end

    // Stray words before a SOP never reach the output.
    iIPG_CNT = 2; log.delete(); sent.delete();
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, 32'h51 + 32'(i));
    send_frame(2, 32'h60);
    idle(20);
    collect();
    chk("stray words", 128'(vw.size()), 128'(2));
    chk("stray first flags", 128'(flags_at(0)), 128'(3'b100));
    chk("stray data", 128'(data_errs()), 128'(0));
    chk("stray trunc", 128'(trunc_count()), 128'(0));

    // Output held in a 15-cycle gap while a 20-word frame arrives: word k lands at level k,
    // so word 15 (the 16th) is cut with EOP/ERR and the rest are discarded.
    iIPG_CNT = 15; log.delete(); sent.delete();
    send(1'b1, 1'b1, 1'b0, 32'h11); sent.push_back(32'h11);
    for (int k = 0; k < 20; k++) begin
      send(k == 0, k == 19, 1'b0, 32'hB00 + 32'(k));
      if (k < 16) sent.push_back(32'hB00 + 32'(k));
    end
    send_frame(3, 32'hC0);
    idle(60);
    collect();
    chk("ovf words", 128'(vw.size()), 128'(20));
    chk("ovf data", 128'(data_errs()), 128'(0));
    chk("ovf cut flags", 128'(flags_at(16)), 128'(3'b011));
    chk("ovf next sop", 128'(flags_at(17)), 128'(3'b100));
    chk("ovf next eop", 128'(flags_at(19)), 128'(3'b010));
    chk("ovf trunc", 128'(trunc_count()), 128'(1));

    // SOP inside an open frame closes it with EOP/ERR; the new frame is dropped to its EOP.
    iIPG_CNT = 2; log.delete(); sent.delete();
    send(1'b1, 1'b0, 1'b0, 32'hD0); sent.push_back(32'hD0);
    send(1'b0, 1'b0, 1'b0, 32'hD1); sent.push_back(32'hD1);
    send(1'b1, 1'b0, 1'b0, 32'hD2); sent.push_back(32'hD2);
    send(1'b0, 1'b0, 1'b0, 32'hE1);
    send(1'b0, 1'b0, 1'b0, 32'hE2);
    send(1'b0, 1'b1, 1'b0, 32'hE3);
    send_frame(2, 32'hF0);
    idle(25);
    collect();
    chk("noeop words", 128'(vw.size()), 128'(5));
    chk("noeop data", 128'(data_errs()), 128'(0));
    chk("noeop cut flags", 128'(flags_at(2)), 128'(3'b011));
    chk("noeop next sop", 128'(flags_at(3)), 128'(3'b100));
    chk("noeop trunc", 128'(trunc_count()), 128'(1));

    // Reset in the middle of a frame, then a clean frame.
    send(1'b1, 1'b0, 1'b0, 32'h71);
    send(1'b0, 1'b0, 1'b0, 32'h72);
    apply_reset("reset mid-frame");
    log.delete(); sent.delete();
    send_frame(2, 32'h80);
    idle(15);
    collect();
    chk("post-reset data", 128'(data_errs()), 128'(0));
    chk("post-reset sop", 128'(flags_at(0)), 128'(3'b100));
    chk("post-reset eop", 128'(flags_at(1)), 128'(3'b010));
`ifdef MTIP_IPG_STATS_EN
    chk("frame count", 128'(oFRAME_CNT), 128'(1));
    chk("trunc count", 128'(oTRUNC_CNT), 128'(0));
`endif

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) iIPG_CNT = IPG_W'($urandom_range(0, 15));
      if (c == 1500) apply_reset("reset random");
      iMTIP_DVAL = ($urandom_range(0, 3) != 0);
      iMTIP_SOP  = ($urandom_range(0, 7) == 0);
      iMTIP_EOP  = ($urandom_range(0, 5) == 0);
      iMTIP_ERR  = ($urandom_range(0, 15) == 0);
      iMTIP_DATA = $urandom;
      step();
    end
    idle(60);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
